// File: rtl/mem_pkg.sv
// Shared types and limits for the mem_if RAM slave.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_if.sv
// Memory port between the AXI4-Lite bridge (master) and the RAM (slave).
// Handshake: wen/ren are one-shot requests taken on the clock edge with no ready;
// rvalid is a single-cycle pulse carrying rdata, and the master must always accept it.
interface mem_if #(
  parameter int ALEN = 10,
  parameter int DLEN = 32
);
  logic            wen;
  logic [ALEN-1:0] waddr;
  logic [DLEN-1:0] wdata;
  logic            ren;
  logic [ALEN-1:0] raddr;
  logic            rvalid;
  logic [DLEN-1:0] rdata;

  modport S (input wen, waddr, wdata, ren, raddr, output rvalid, rdata);
  modport M (output wen, waddr, wdata, ren, raddr, input rvalid, rdata);
endinterface

// File: rtl/mem_rd_pipe.sv
// Read-response shift register: fixed RD_LAT latency, one response per issued read.
module mem_rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int DLEN   = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [DLEN-1:0] in_data,
  output logic            rvalid,
  output logic [DLEN-1:0] rdata
);

  logic [RD_LAT-1:0] v;
  logic [DLEN-1:0]   d [RD_LAT];

  // Data is zeroed when a slot is empty, so rdata is 0 whenever rvalid is 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v <= '0;
      for (int i = 0; i < RD_LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign rvalid = v[RD_LAT-1];
  assign rdata  = d[RD_LAT-1];

endmodule

// File: rtl/mem_if_ram.sv
// Synchronous RAM slave on mem_if with pipelined reads, write/read collision bypass
// and an optional post-reset zero-fill during which requests are dropped.
module mem_if_ram
  import mem_pkg::*;
#(
  parameter int ALEN         = 10,
  parameter int DLEN         = 32,
  parameter int RD_LAT       = 1,
  parameter bit WRITE_FIRST  = 1'b1,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  mem_if.S           mem,
  output logic       init_busy,
  output logic       mem_drop,
  output ram_state_e state
);

  localparam int DEPTH = 1 << ALEN;

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_if_ram: RD_LAT must be in 1..%0d", RD_LAT_MAX);
  end

  logic [DLEN-1:0] ram [DEPTH];
  logic [ALEN-1:0] clr_addr;
  logic            ready;
  logic            wr_ok;
  logic            rd_ok;
  logic            bypass;
  logic [DLEN-1:0] rd_word;

  assign ready   = (state == READY);
  assign wr_ok   = rstn && ready && mem.wen;
  assign rd_ok   = ready && mem.ren;
  assign bypass  = WRITE_FIRST && mem.wen && (mem.waddr == mem.raddr);
  assign rd_word = bypass ? mem.wdata : ram[mem.raddr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= CLEAR_ON_RST ? CLEAR : READY;
      clr_addr  <= '0;
      init_busy <= CLEAR_ON_RST;
      mem_drop  <= 1'b0;
    end else begin
      mem_drop <= (state == CLEAR) && (mem.wen || mem.ren);
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state     <= READY;
            init_busy <= 1'b0;
          end
        end
        READY: ;
        default: state <= READY;
      endcase
    end
  end

  // Array has no reset; only the zero-fill touches it outside normal writes.
  always_ff @(posedge clk) begin
    if (rstn && state == CLEAR) ram[clr_addr] <= '0;
    else if (wr_ok)             ram[mem.waddr] <= mem.wdata;
  end

  mem_rd_pipe #(
    .RD_LAT (RD_LAT),
    .DLEN   (DLEN)
  ) u_rd_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (rd_ok),
    .in_data  (rd_word),
    .rvalid   (mem.rvalid),
    .rdata    (mem.rdata)
  );

endmodule

// File: tb/tb_mem_if_ram.sv
// Bench for mem_if_ram: two instances (write-first RD_LAT=2, read-first RD_LAT=3)
// driven with identical directed stimulus, each with its own expected-response queue.
module tb_mem_if_ram;
  import mem_pkg::*;

  localparam int ALEN  = 4;
  localparam int DLEN  = 32;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  typedef struct {
    logic [DLEN-1:0] data;
    int              cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       busy_a, busy_b, drop_a, drop_b;
  ram_state_e state_a, state_b;
  exp_t       exp_qa[$];
  exp_t       exp_qb[$];

  mem_if #(.ALEN(ALEN), .DLEN(DLEN)) if_a ();
  mem_if #(.ALEN(ALEN), .DLEN(DLEN)) if_b ();

  mem_if_ram #(.ALEN(ALEN), .DLEN(DLEN), .RD_LAT(LAT_A), .WRITE_FIRST(1'b1), .CLEAR_ON_RST(1'b1))
    u_a (.clk(clk), .rstn(rstn), .mem(if_a), .init_busy(busy_a), .mem_drop(drop_a), .state(state_a));
  mem_if_ram #(.ALEN(ALEN), .DLEN(DLEN), .RD_LAT(LAT_B), .WRITE_FIRST(1'b0), .CLEAR_ON_RST(1'b1))
    u_b (.clk(clk), .rstn(rstn), .mem(if_b), .init_busy(busy_b), .mem_drop(drop_b), .state(state_b));

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // monitors
  always @(negedge clk) begin
    if (if_a.rvalid) begin
      checks++;
      if (exp_qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_rvalid cyc=%0d rdata=%h", cyc, if_a.rdata);
      end else begin
        exp_t e;
        e = exp_qa.pop_front();
        if (if_a.rdata !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL a_rsp got data=%h cyc=%0d want data=%h cyc=%0d", if_a.rdata, cyc, e.data, e.cyc);
        end
      end
    end else begin
      checks++;
      if (if_a.rdata !== '0) begin
        errors++;
        $display("FAIL a_idle_rdata got %h want 0", if_a.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.rvalid) begin
      checks++;
      if (exp_qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_rvalid cyc=%0d rdata=%h", cyc, if_b.rdata);
      end else begin
        exp_t e;
        e = exp_qb.pop_front();
        if (if_b.rdata !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL b_rsp got data=%h cyc=%0d want data=%h cyc=%0d", if_b.rdata, cyc, e.data, e.cyc);
        end
      end
    end else begin
      checks++;
      if (if_b.rdata !== '0) begin
        errors++;
        $display("FAIL b_idle_rdata got %h want 0", if_b.rdata);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic wen, input logic [ALEN-1:0] waddr, input logic [DLEN-1:0] wdata,
                        input logic ren, input logic [ALEN-1:0] raddr);
    if_a.wen = wen; if_a.waddr = waddr; if_a.wdata = wdata; if_a.ren = ren; if_a.raddr = raddr;
    if_b.wen = wen; if_b.waddr = waddr; if_b.wdata = wdata; if_b.ren = ren; if_b.raddr = raddr;
  endtask

  task automatic expect_rd(input logic [DLEN-1:0] da, input logic [DLEN-1:0] db);
    exp_qa.push_back('{data: da, cyc: cyc + LAT_A});
    exp_qb.push_back('{data: db, cyc: cyc + LAT_B});
  endtask

  task automatic wr(input logic [ALEN-1:0] a, input logic [DLEN-1:0] d);
    set_in(1'b1, a, d, 1'b0, '0);
    step();
    set_in(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [ALEN-1:0] a, input logic [DLEN-1:0] da, input logic [DLEN-1:0] db);
    set_in(1'b0, '0, '0, 1'b1, a);
    expect_rd(da, db);
    step();
    set_in(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr_rd(input logic [ALEN-1:0] wa, input logic [DLEN-1:0] wd, input logic [ALEN-1:0] ra,
                       input logic [DLEN-1:0] da, input logic [DLEN-1:0] db);
    set_in(1'b1, wa, wd, 1'b1, ra);
    expect_rd(da, db);
    step();
    set_in(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic chk(input string name, input logic [DLEN-1:0] got, input logic [DLEN-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_reset();
    chk("a_rst_rvalid", DLEN'(if_a.rvalid), 0);
    chk("a_rst_rdata", if_a.rdata, 0);
    chk("a_rst_drop", DLEN'(drop_a), 0);
    chk("a_rst_busy", DLEN'(busy_a), 1);
    chk("b_rst_rvalid", DLEN'(if_b.rvalid), 0);
    chk("b_rst_rdata", if_b.rdata, 0);
    chk("b_rst_drop", DLEN'(drop_b), 0);
    chk("b_rst_busy", DLEN'(busy_b), 1);
  endtask

  // Runs from reset release until both fills finish (bounded); optionally issues a read of addr 2
  // at loop index drop_at to exercise the drop path.
  task automatic clear_phase(input int drop_at, input int want_drops);
    int na = 0, nb = 0, da = 0, db = 0;
    for (int i = 0; i < 40 && (busy_a || busy_b); i++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      if (drop_a) da++;
      if (drop_b) db++;
      if (i == drop_at) set_in(1'b0, '0, '0, 1'b1, 4'd2);
      else              set_in(1'b0, '0, '0, 1'b0, '0);
      step();
    end
    set_in(1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      if (drop_a) da++;
      if (drop_b) db++;
      step();
    end
    chk("a_busy_cycles", DLEN'(na), DLEN'(1 << ALEN));
    chk("b_busy_cycles", DLEN'(nb), DLEN'(1 << ALEN));
    chk("a_drop_pulses", DLEN'(da), DLEN'(want_drops));
    chk("b_drop_pulses", DLEN'(db), DLEN'(want_drops));
    chk("a_state_ready", DLEN'(state_a), DLEN'(READY));
    chk("b_state_ready", DLEN'(state_b), DLEN'(READY));
  endtask

  initial begin
    set_in(1'b0, '0, '0, 1'b0, '0);
    rstn = 1'b0;
    step();
    step();
    check_reset();
    rstn = 1'b1;
    clear_phase(-1, 0);

    // junk pre-load, then reset and a fill with a dropped read at its third cycle
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hA5A5_0000 | 32'(i));
    rstn = 1'b0;
    step();
    step();
    check_reset();
    rstn = 1'b1;
    clear_phase(2, 1);
    rd(4'hF, 32'h0, 32'h0);
    rd(4'h2, 32'h0, 32'h0);

    // write then read back on the next cycle
    wr(4'd3, 32'hDEAD_BEEF);
    rd(4'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // same-address collision, then a different-address pair
    wr(4'd5, 32'h0000_AAAA);
    wr_rd(4'd5, 32'h0000_1234, 4'd5, 32'h0000_1234, 32'h0000_AAAA);
    rd(4'd5, 32'h0000_1234, 32'h0000_1234);
    wr_rd(4'd6, 32'h0000_5555, 4'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    rd(4'd6, 32'h0000_5555, 32'h0000_5555);

    // back-to-back reads
    for (int i = 0; i < 8; i++) wr(4'(i), 32'(i * 32'h11));
    for (int i = 0; i < 8; i++) rd(4'(i), 32'(i * 32'h11), 32'(i * 32'h11));
    for (int i = 0; i < 6; i++) step();

    // reset with reads in flight: only the response that completes before the reset edge survives
    set_in(1'b0, '0, '0, 1'b1, 4'd4);
    exp_qa.push_back('{data: 32'h44, cyc: cyc + LAT_A});
    step();
    set_in(1'b0, '0, '0, 1'b1, 4'd5);
    step();
    set_in(1'b0, '0, '0, 1'b0, '0);
    rstn = 1'b0;
    step();
    step();
    step();
    check_reset();
    rstn = 1'b1;
    clear_phase(-1, 0);
    rd(4'd4, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) step();

    chk("a_queue_empty", DLEN'(exp_qa.size()), 0);
    chk("b_queue_empty", DLEN'(exp_qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
